// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared types and constants for the SPI register sequencer
package spi_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SEND_CMD,
      WAIT_CMD,
      SEND_DATA,
      WAIT_DATA,
      CS_HOLD,
      GAP
   } seq_state_t;

   localparam int         RW_BIT_POS      = 7;
   localparam logic [7:0] READ_DUMMY_BYTE = 8'h00;

   // Counter width able to hold max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/spi_reg_sequencer_if.sv
// rtl/spi_reg_sequencer_if.sv - request/response and SPI byte-engine signals of the sequencer
interface spi_reg_sequencer_if;

   logic       i_Req_Valid;
   logic       o_Req_Ready;
   logic       i_Req_Write;
   logic [6:0] i_Req_Addr;
   logic [7:0] i_Req_Wdata;
   logic       o_Rsp_Valid;
   logic [7:0] o_Rsp_Rdata;
   logic [7:0] o_TX_Byte;
   logic       o_TX_DV;
   logic       i_TX_Ready;
   logic       i_RX_DV;
   logic [7:0] i_RX_Byte;
   logic       o_CS_n;
   logic       o_Busy;

   // Sequencer side.
   modport slave (
      input  i_Req_Valid, i_Req_Write, i_Req_Addr, i_Req_Wdata,
      input  i_TX_Ready, i_RX_DV, i_RX_Byte,
      output o_Req_Ready, o_Rsp_Valid, o_Rsp_Rdata,
      output o_TX_Byte, o_TX_DV, o_CS_n, o_Busy
   );

   // Host plus byte-engine side.
   modport master (
      output i_Req_Valid, i_Req_Write, i_Req_Addr, i_Req_Wdata,
      output i_TX_Ready, i_RX_DV, i_RX_Byte,
      input  o_Req_Ready, o_Rsp_Valid, o_Rsp_Rdata,
      input  o_TX_Byte, o_TX_DV, o_CS_n, o_Busy
   );

endinterface

// File: rtl/spi_seq_delay_cnt.sv
// rtl/spi_seq_delay_cnt.sv - loadable down-counter shared by the CS setup, CS hold and gap phases
module spi_seq_delay_cnt #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   // Load wins over counting; the count parks at zero until reloaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/spi_reg_sequencer.sv
// rtl/spi_reg_sequencer.sv - turns register requests into 2-byte SPI frames on the byte engine
module spi_reg_sequencer
   import spi_seq_pkg::*;
#(
   parameter int CS_SETUP_CLKS = 2,
   parameter int CS_HOLD_CLKS  = 2,
   parameter int IDLE_GAP_CLKS = 4
) (
   input logic                 i_Clk,
   input logic                 i_Rst,
   spi_reg_sequencer_if.slave  bus
);

   localparam int MAX_SH   = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
   localparam int MAX_CLKS = (MAX_SH > IDLE_GAP_CLKS) ? MAX_SH : IDLE_GAP_CLKS;
   localparam int CW       = cnt_width(MAX_CLKS);

   // The counter is loaded with N-1 so a phase of N cycles ends on the cycle it reads zero.
   localparam logic [CW-1:0] SETUP_LD = CW'((CS_SETUP_CLKS > 0) ? CS_SETUP_CLKS - 1 : 0);
   localparam logic [CW-1:0] HOLD_LD  = CW'((CS_HOLD_CLKS  > 0) ? CS_HOLD_CLKS  - 1 : 0);
   localparam logic [CW-1:0] GAP_LD   = CW'((IDLE_GAP_CLKS > 0) ? IDLE_GAP_CLKS - 1 : 0);

   seq_state_t    state, state_nxt;
   logic          req_write_q;
   logic [7:0]    data_byte_q;
   logic [7:0]    tx_byte_q;
   logic          rsp_valid_q;
   logic [7:0]    rsp_rdata_q;

   logic          cnt_load;
   logic [CW-1:0] cnt_val;
   logic          cnt_done;
   logic          accept;
   logic          load_data;
   logic          tx_dv;
   logic          rsp_fire;
   logic          rdata_latch;
   logic [7:0]    cmd_byte;

   spi_seq_delay_cnt #(.W(CW)) u_delay_cnt (
      .clk      (i_Clk),
      .rst      (i_Rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .done     (cnt_done)
   );

   // Next state, counter loads and strobes; zero-length phases are bypassed entirely.
   always_comb begin
      state_nxt   = state;
      cnt_load    = 1'b0;
      cnt_val     = '0;
      accept      = 1'b0;
      load_data   = 1'b0;
      tx_dv       = 1'b0;
      rsp_fire    = 1'b0;
      rdata_latch = 1'b0;
      cmd_byte    = {1'b0, bus.i_Req_Addr};
      cmd_byte[RW_BIT_POS] = bus.i_Req_Write;

      case (state)
         IDLE: begin
            if (bus.i_Req_Valid) begin
               accept = 1'b1;
               if (CS_SETUP_CLKS > 0) begin
                  state_nxt = CS_SETUP;
                  cnt_load  = 1'b1;
                  cnt_val   = SETUP_LD;
               end else begin
                  state_nxt = SEND_CMD;
               end
            end
         end
         CS_SETUP: begin
            if (cnt_done) state_nxt = SEND_CMD;
         end
         SEND_CMD: begin
            if (bus.i_TX_Ready) begin
               tx_dv     = 1'b1;
               state_nxt = WAIT_CMD;
            end
         end
         WAIT_CMD: begin
            if (bus.i_RX_DV) begin
               load_data = 1'b1;
               state_nxt = SEND_DATA;
            end
         end
         SEND_DATA: begin
            if (bus.i_TX_Ready) begin
               tx_dv     = 1'b1;
               state_nxt = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (bus.i_RX_DV) begin
               rdata_latch = !req_write_q;
               if (CS_HOLD_CLKS > 0) begin
                  state_nxt = CS_HOLD;
                  cnt_load  = 1'b1;
                  cnt_val   = HOLD_LD;
               end else begin
                  rsp_fire = 1'b1;
                  if (IDLE_GAP_CLKS > 0) begin
                     state_nxt = GAP;
                     cnt_load  = 1'b1;
                     cnt_val   = GAP_LD;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         CS_HOLD: begin
            if (cnt_done) begin
               rsp_fire = 1'b1;
               if (IDLE_GAP_CLKS > 0) begin
                  state_nxt = GAP;
                  cnt_load  = 1'b1;
                  cnt_val   = GAP_LD;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         GAP: begin
            if (cnt_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register plus frame bytes and response capture.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state       <= IDLE;
         req_write_q <= 1'b0;
         data_byte_q <= 8'h00;
         tx_byte_q   <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
      end else begin
         state       <= state_nxt;
         rsp_valid_q <= rsp_fire;
         if (accept) begin
            req_write_q <= bus.i_Req_Write;
            data_byte_q <= bus.i_Req_Write ? bus.i_Req_Wdata : READ_DUMMY_BYTE;
            tx_byte_q   <= cmd_byte;
         end else if (load_data) begin
            tx_byte_q <= data_byte_q;
         end
         if (rdata_latch) rsp_rdata_q <= bus.i_RX_Byte;
      end
   end

   assign bus.o_Req_Ready = (state == IDLE);
   assign bus.o_Busy      = (state != IDLE);
   assign bus.o_CS_n      = (state == IDLE) || (state == GAP);
   assign bus.o_TX_DV     = tx_dv;
   assign bus.o_TX_Byte   = tx_byte_q;
   assign bus.o_Rsp_Valid = rsp_valid_q;
   assign bus.o_Rsp_Rdata = rsp_rdata_q;

endmodule
